toy_trap_csr: RTL

Trap/return CSR responder. It is the receiving end of the retire unit's trap_vld/trap_rdy handshake and return strobes (mret/sret/dret), and of its debug-entry request. It owns the M/S trap CSRs, the debug CSRs and the privilege mode, and feeds the vectors and return addresses (mtvec, mepc, stvec, sepc, dpc) plus delegation and debug state back to the retire unit. A software CSR read/write port from the CSR execution unit shares the same registers.

---
 rtl/toy_trap_csr_pkg.sv | 57 +++++
 rtl/toy_trap_csr.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/toy_trap_csr_pkg.sv
// rtl/toy_trap_csr_pkg.sv - CSR addresses, privilege encodings and mstatus layout for the trap CSR block
package toy_trap_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEDELEG = 12'h302;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_SSTATUS = 12'h100;
    localparam logic [11:0] CSR_STVEC   = 12'h105;
    localparam logic [11:0] CSR_SEPC    = 12'h141;
    localparam logic [11:0] CSR_SCAUSE  = 12'h142;
    localparam logic [11:0] CSR_STVAL   = 12'h143;
    localparam logic [11:0] CSR_DCSR    = 12'h7B0;
    localparam logic [11:0] CSR_DPC     = 12'h7B1;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    localparam logic [31:0] SSTATUS_MASK = 32'h0000_0122;

    typedef enum logic {
        ST_IDLE,
        ST_COMMIT
    } trap_state_e;

    typedef struct packed {
        logic [18:0] rsvd_31_13;
        logic [1:0]  mpp;
        logic [1:0]  rsvd_10_9;
        logic        spp;
        logic        mpie;
        logic        rsvd_6;
        logic        spie;
        logic        rsvd_4;
        logic        mie;
        logic        rsvd_2;
        logic        sie;
        logic        rsvd_0;
    } mstatus_t;

    // MPP=10 (reserved H-mode) is folded to U so an illegal level is never stored
    function automatic mstatus_t mstatus_wr(input logic [31:0] d);
        mstatus_t m;
        m      = '0;
        m.sie  = d[1];
        m.mie  = d[3];
        m.spie = d[5];
        m.mpie = d[7];
        m.spp  = d[8];
        m.mpp  = (d[12:11] == 2'b10) ? PRIV_U : d[12:11];
        return m;
    endfunction

endpackage

// File: rtl/toy_trap_csr.sv
// rtl/toy_trap_csr.sv - trap/return CSR responder owning M/S trap CSRs, debug CSRs and privilege mode
module toy_trap_csr
    import toy_trap_csr_pkg::*;
#(
    parameter int                   REG_WIDTH  = 32,
    parameter int                   ADDR_WIDTH = 32,
    parameter logic [REG_WIDTH-1:0] MTVEC_RST  = 32'h0000_0000,
    parameter logic [REG_WIDTH-1:0] STVEC_RST  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  trap_vld,
    input  logic [ADDR_WIDTH-1:0] trap_pc,
    input  logic [5:0]            trap_cause,
    input  logic [ADDR_WIDTH-1:0] trap_extra_info,
    input  logic                  trap_indebug,
    output logic                  trap_rdy,
    input  logic                  mret_en,
    input  logic                  sret_en,
    input  logic                  dret_en,
    input  logic                  debug_vld,
    input  logic [2:0]            debug_cause,
    input  logic [ADDR_WIDTH-1:0] debug_pc,
    input  logic                  csr_wr_en,
    input  logic [11:0]           csr_addr,
    input  logic [REG_WIDTH-1:0]  csr_wr_data,
    output logic [REG_WIDTH-1:0]  csr_rd_data,
    output logic [REG_WIDTH-1:0]  csr_mtvec,
    output logic [REG_WIDTH-1:0]  csr_mepc,
    output logic [REG_WIDTH-1:0]  csr_stvec,
    output logic [REG_WIDTH-1:0]  csr_sepc,
    output logic [REG_WIDTH-1:0]  csr_dpc,
    output logic                  trap_enter_smode,
    output logic                  debug_mode_en,
    output logic                  debug_ebreakm,
    output logic                  debug_step_en,
    output logic [1:0]            priv_mode
);

    trap_state_e           r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_lat_pc, r_lat_info;
    logic [5:0]            r_lat_cause;
    logic                  r_lat_indebug, r_lat_smode;
    mstatus_t              r_mstatus;
    logic [REG_WIDTH-1:0]  r_medeleg, r_mtvec, r_mepc, r_mcause, r_mtval;
    logic [REG_WIDTH-1:0]  r_stvec, r_sepc, r_scause, r_stval, r_dpc;
    logic [2:0]            r_dcsr_cause;
    logic                  r_ebreakm, r_step, r_debug_mode;
    logic [1:0]            r_dcsr_prv, r_priv;

    logic                  w_commit_m, w_commit_s, w_dbg_enter, w_dret, w_mret, w_sret;
    logic [REG_WIDTH-1:0]  w_epc, w_cause, w_tval;
    logic [31:0]           w_dcsr;

    always_comb begin
        w_state_nxt = r_state;
        trap_rdy    = 1'b0;
        case (r_state)
            ST_IDLE:   if (trap_vld) w_state_nxt = ST_COMMIT;
            ST_COMMIT: begin
                trap_rdy    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Event priority: commit > debug entry > returns > software write
    assign w_commit_m  = (r_state == ST_COMMIT) && !r_lat_indebug && !r_lat_smode;
    assign w_commit_s  = (r_state == ST_COMMIT) && !r_lat_indebug &&  r_lat_smode;
    assign w_dbg_enter = debug_vld && !r_debug_mode;
    assign w_dret      = dret_en && r_debug_mode;
    assign w_mret      = mret_en && (r_state == ST_IDLE) && !w_dbg_enter;
    assign w_sret      = sret_en && (r_state == ST_IDLE) && !w_dbg_enter;

    assign w_epc   = REG_WIDTH'({r_lat_pc[ADDR_WIDTH-1:2], 2'b00});
    assign w_cause = {r_lat_cause[5], {(REG_WIDTH-6){1'b0}}, r_lat_cause[4:0]};
    assign w_tval  = REG_WIDTH'(r_lat_info);
    assign w_dcsr  = {4'd4, 12'd0, r_ebreakm, 6'd0, r_dcsr_cause, 3'd0, r_step, r_dcsr_prv};

    assign trap_enter_smode = !trap_cause[5] && r_medeleg[trap_cause[4:0]] && (r_priv != PRIV_M);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_lat_pc      <= '0;
            r_lat_info    <= '0;
            r_lat_cause   <= '0;
            r_lat_indebug <= 1'b0;
            r_lat_smode   <= 1'b0;
            r_mstatus     <= '0;
            r_medeleg     <= '0;
            r_mtvec       <= MTVEC_RST;
            r_mepc        <= '0;
            r_mcause      <= '0;
            r_mtval       <= '0;
            r_stvec       <= STVEC_RST;
            r_sepc        <= '0;
            r_scause      <= '0;
            r_stval       <= '0;
            r_dpc         <= '0;
            r_dcsr_cause  <= '0;
            r_ebreakm     <= 1'b0;
            r_step        <= 1'b0;
            r_dcsr_prv    <= PRIV_M;
            r_debug_mode  <= 1'b0;
            r_priv        <= PRIV_M;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && trap_vld) begin
                r_lat_pc      <= trap_pc;
                r_lat_info    <= trap_extra_info;
                r_lat_cause   <= trap_cause;
                r_lat_indebug <= trap_indebug;
                r_lat_smode   <= trap_enter_smode;
            end

            if (w_commit_m) begin
                r_mepc   <= w_epc;
                r_mcause <= w_cause;
                r_mtval  <= w_tval;
            end else if (csr_wr_en) begin
                if (csr_addr == CSR_MEPC)   r_mepc   <= {csr_wr_data[REG_WIDTH-1:1], 1'b0};
                if (csr_addr == CSR_MCAUSE) r_mcause <= csr_wr_data;
                if (csr_addr == CSR_MTVAL)  r_mtval  <= csr_wr_data;
            end

            if (w_commit_s) begin
                r_sepc   <= w_epc;
                r_scause <= w_cause;
                r_stval  <= w_tval;
            end else if (csr_wr_en) begin
                if (csr_addr == CSR_SEPC)   r_sepc   <= {csr_wr_data[REG_WIDTH-1:1], 1'b0};
                if (csr_addr == CSR_SCAUSE) r_scause <= csr_wr_data;
                if (csr_addr == CSR_STVAL)  r_stval  <= csr_wr_data;
            end

            if (csr_wr_en && csr_addr == CSR_MEDELEG) r_medeleg <= csr_wr_data;
            if (csr_wr_en && csr_addr == CSR_MTVEC)   r_mtvec   <= {csr_wr_data[REG_WIDTH-1:2], 2'b00};
            if (csr_wr_en && csr_addr == CSR_STVEC)   r_stvec   <= {csr_wr_data[REG_WIDTH-1:2], 2'b00};

            if (w_commit_m) begin
                r_mstatus.mpie <= r_mstatus.mie;
                r_mstatus.mie  <= 1'b0;
                r_mstatus.mpp  <= r_priv;
            end else if (w_commit_s) begin
                r_mstatus.spie <= r_mstatus.sie;
                r_mstatus.sie  <= 1'b0;
                r_mstatus.spp  <= r_priv[0];
            end else if (w_mret) begin
                r_mstatus.mie  <= r_mstatus.mpie;
                r_mstatus.mpie <= 1'b1;
                r_mstatus.mpp  <= PRIV_U;
            end else if (w_sret) begin
                r_mstatus.sie  <= r_mstatus.spie;
                r_mstatus.spie <= 1'b1;
                r_mstatus.spp  <= 1'b0;
            end else if (csr_wr_en && csr_addr == CSR_MSTATUS) begin
                r_mstatus <= mstatus_wr(32'(csr_wr_data));
            end else if (csr_wr_en && csr_addr == CSR_SSTATUS) begin
                r_mstatus.sie  <= csr_wr_data[1];
                r_mstatus.spie <= csr_wr_data[5];
                r_mstatus.spp  <= csr_wr_data[8];
            end

            if (w_dbg_enter) begin
                r_dpc        <= REG_WIDTH'(debug_pc);
                r_dcsr_cause <= debug_cause;
                r_dcsr_prv   <= r_priv;
                r_debug_mode <= 1'b1;
            end else begin
                if (w_dret) r_debug_mode <= 1'b0;
                if (csr_wr_en && csr_addr == CSR_DPC) r_dpc <= {csr_wr_data[REG_WIDTH-1:1], 1'b0};
                if (csr_wr_en && csr_addr == CSR_DCSR) begin
                    r_ebreakm  <= csr_wr_data[15];
                    r_step     <= csr_wr_data[2];
                    r_dcsr_prv <= csr_wr_data[1:0];
                end
            end

            if (w_commit_m || w_dbg_enter) r_priv <= PRIV_M;
            else if (w_commit_s)           r_priv <= PRIV_S;
            else if (w_dret)               r_priv <= r_dcsr_prv;
            else if (w_mret)               r_priv <= r_mstatus.mpp;
            else if (w_sret)               r_priv <= {1'b0, r_mstatus.spp};
        end
    end

    always_comb begin
        csr_rd_data = '0;
        case (csr_addr)
            CSR_MSTATUS: csr_rd_data = REG_WIDTH'(r_mstatus);
            CSR_SSTATUS: csr_rd_data = REG_WIDTH'(r_mstatus & SSTATUS_MASK);
            CSR_MEDELEG: csr_rd_data = r_medeleg;
            CSR_MTVEC:   csr_rd_data = r_mtvec;
            CSR_MEPC:    csr_rd_data = r_mepc;
            CSR_MCAUSE:  csr_rd_data = r_mcause;
            CSR_MTVAL:   csr_rd_data = r_mtval;
            CSR_STVEC:   csr_rd_data = r_stvec;
            CSR_SEPC:    csr_rd_data = r_sepc;
            CSR_SCAUSE:  csr_rd_data = r_scause;
            CSR_STVAL:   csr_rd_data = r_stval;
            CSR_DCSR:    csr_rd_data = REG_WIDTH'(w_dcsr);
            CSR_DPC:     csr_rd_data = r_dpc;
            default:     csr_rd_data = '0;
        endcase
    end

    assign csr_mtvec     = r_mtvec;
    assign csr_mepc      = r_mepc;
    assign csr_stvec     = r_stvec;
    assign csr_sepc      = r_sepc;
    assign csr_dpc       = r_dpc;
    assign debug_mode_en = r_debug_mode;
    assign debug_ebreakm = r_ebreakm;
    assign debug_step_en = r_step;
    assign priv_mode     = r_priv;

endmodule
